// File: rtl/simple_alu_pkg.sv
// Shared types for the SIMPLE multi-cycle ALU: opcodes, FSM states, default width.
// Latency: n/a (types only).
// Backpressure: n/a.
package simple_alu_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_CMP = 4'd5,
        OP_MOV = 4'd6,
        OP_SLL = 4'd8,
        OP_ROL = 4'd9,
        OP_SRL = 4'd10,
        OP_SRA = 4'd11,
        OP_IN  = 4'd12
    } opcode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Shift opcodes occupy 8..11; the low two bits select the step kind.
    function automatic logic is_shift(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/simple_alu_shift_step.sv
// One-bit SLL/ROL/SRL/SRA step returning the shifted word and the bit pushed out.
// Latency: combinational.
// Backpressure: none.
module simple_alu_shift_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       kind,
    output logic [WIDTH-1:0] shifted,
    output logic             bit_out
);

    always_comb begin
        shifted = word;
        bit_out = 1'b0;
        case (kind)
            2'b00: begin
                shifted = {word[WIDTH-2:0], 1'b0};
                bit_out = word[WIDTH-1];
            end
            2'b01: begin
                shifted = {word[WIDTH-2:0], word[WIDTH-1]};
                bit_out = word[WIDTH-1];
            end
            2'b10: begin
                shifted = {1'b0, word[WIDTH-1:1]};
                bit_out = word[0];
            end
            2'b11: begin
                shifted = {word[WIDTH-1], word[WIDTH-1:1]};
                bit_out = word[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/simple_alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, shifts iterate one bit per cycle.
// Latency: 1 cycle for non-shift ops or n=0, n+1 cycles for shifts by n.
// Backpressure: busy high while shifting; start is ignored until it drops.
module simple_alu_mc
    import simple_alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] dipswitch,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic             v,
    output logic             z,
    output logic             c,
    output logic             s
);

    state_e             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         kind;

    opcode_e            op;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    logic [WIDTH-1:0]   nx_res;
    logic               nx_v, nx_c, nx_z, nx_s, nx_we, nx_def;

    logic [WIDTH-1:0]   step_word;
    logic               step_out;

    assign op    = opcode_e'(opcode);
    assign shamt = in2[SHAMT_W-1:0];
    assign sum   = {1'b0, in1} + {1'b0, in2};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff  = {1'b0, in1} - {1'b0, in2};
    assign busy  = (state == S_SHIFT);

    always_comb begin
        nx_res = '0;
        nx_v   = 1'b0;
        nx_c   = 1'b0;
        nx_we  = 1'b0;
        nx_def = 1'b1;
        case (op)
            OP_ADD: begin
                nx_res = sum[WIDTH-1:0];
                nx_c   = sum[WIDTH];
                nx_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
                nx_we  = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                nx_res = diff[WIDTH-1:0];
                nx_c   = diff[WIDTH];
                nx_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
                nx_we  = (op == OP_SUB);
            end
            OP_AND: begin nx_res = in1 & in2; nx_we = 1'b1; end
            OP_OR:  begin nx_res = in1 | in2; nx_we = 1'b1; end
            OP_XOR: begin nx_res = in1 ^ in2; nx_we = 1'b1; end
            OP_MOV: begin nx_res = in1;       nx_we = 1'b1; end
            OP_IN:  begin nx_res = dipswitch; nx_we = 1'b1; end
            // Only reached here with a zero shift amount: pass in1 through.
            OP_SLL, OP_ROL, OP_SRL, OP_SRA: begin nx_res = in1; nx_we = 1'b1; end
            default: nx_def = 1'b0;
        endcase
        nx_z = nx_def & ~|nx_res;
        nx_s = nx_def & nx_res[WIDTH-1];
    end

    simple_alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .word    (work),
        .kind    (kind),
        .shifted (step_word),
        .bit_out (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            work      <= '0;
            cnt       <= '0;
            kind      <= 2'b00;
            result    <= '0;
            result_we <= 1'b0;
            done      <= 1'b0;
            v         <= 1'b0;
            z         <= 1'b0;
            c         <= 1'b0;
            s         <= 1'b0;
        end else begin
            done      <= 1'b0;
            result_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_shift(opcode) && (shamt != '0)) begin
                            work  <= in1;
                            cnt   <= shamt;
                            kind  <= opcode[1:0];
                            state <= S_SHIFT;
                        end else begin
                            result    <= nx_res;
                            v         <= nx_v;
                            c         <= nx_c;
                            z         <= nx_z;
                            s         <= nx_s;
                            result_we <= nx_we;
                            done      <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    work <= step_word;
                    cnt  <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        result    <= step_word;
                        v         <= 1'b0;
                        c         <= step_out;
                        z         <= ~|step_word;
                        s         <= step_word[WIDTH-1];
                        result_we <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_alu_mc.sv
// Directed-vector bench for simple_alu_mc at WIDTH=16.
// Inputs change and outputs are sampled on the falling edge.
module tb_simple_alu_mc;
    import simple_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  opcode;
    logic [15:0] in1, in2, dipswitch;
    logic        busy, done, result_we, v, z, c, s;
    logic [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    simple_alu_mc #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .in1       (in1),
        .in2       (in2),
        .dipswitch (dipswitch),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_we (result_we),
        .v         (v),
        .z         (z),
        .c         (c),
        .s         (s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present one request for a single edge; returns in the cycle after acceptance.
    task automatic go(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] d);
        opcode    = op;
        in1       = a;
        in2       = b;
        dipswitch = d;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    // Flags packed as {v,z,c,s}.
    function automatic logic [3:0] flags();
        return {v, z, c, s};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 4'd0;
        in1 = '0; in2 = '0; dipswitch = '0;
        cyc(); cyc();
        check("rst_result", result, 16'h0);
        check("rst_flags", flags(), 4'b0000);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_we", result_we, 1'b0);
        rst = 1'b0;
        cyc();

        go(OP_ADD, 16'h7FFF, 16'h0001, 16'h0);
        check("add_done", done, 1'b1);
        check("add_result", result, 16'h8000);
        check("add_flags", flags(), 4'b1001);
        check("add_we", result_we, 1'b1);
        cyc();
        check("add_done_pulse", done, 1'b0);
        check("add_hold", result, 16'h8000);

        go(OP_SUB, 16'h0000, 16'h0001, 16'h0);
        check("sub_result", result, 16'hFFFF);
        check("sub_flags", flags(), 4'b0011);
        check("sub_we", result_we, 1'b1);

        go(OP_CMP, 16'h0005, 16'h0005, 16'h0);
        check("cmp_done", done, 1'b1);
        check("cmp_flags", flags(), 4'b0100);
        check("cmp_we", result_we, 1'b0);
        cyc();

        // SRA by 3 with a stray ADD request while busy.
        go(OP_SRA, 16'h8001, 16'h0003, 16'h0);
        check("sra_busy1", busy, 1'b1);
        check("sra_nodone1", done, 1'b0);
        opcode = OP_ADD; in1 = 16'h0001; in2 = 16'h0001; start = 1'b1;
        cyc();
        start = 1'b0;
        check("sra_busy2", busy, 1'b1);
        check("sra_result_held", result, 16'h0000);
        cyc();
        check("sra_busy3", busy, 1'b1);
        check("sra_nodone3", done, 1'b0);
        cyc();
        check("sra_done", done, 1'b1);
        check("sra_busy_low", busy, 1'b0);
        check("sra_result", result, 16'hF000);
        check("sra_flags", flags(), 4'b0001);
        check("sra_we", result_we, 1'b1);
        cyc();
        check("sra_no_extra_done", done, 1'b0);

        go(OP_ROL, 16'h8001, 16'h0001, 16'h0);
        check("rol_busy", busy, 1'b1);
        check("rol_nodone", done, 1'b0);
        cyc();
        check("rol_done", done, 1'b1);
        check("rol_result", result, 16'h0003);
        check("rol_flags", flags(), 4'b0010);

        // Upper bits of in2 ignored: 0xFFF4 shifts by 4.
        go(OP_SRL, 16'h00F8, 16'hFFF4, 16'h0);
        cyc(); cyc(); cyc();
        check("srl_nodone", done, 1'b0);
        cyc();
        check("srl_done", done, 1'b1);
        check("srl_result", result, 16'h000F);
        check("srl_flags", flags(), 4'b0010);

        go(OP_SLL, 16'h1234, 16'h0010, 16'h0);
        check("sll0_done", done, 1'b1);
        check("sll0_busy", busy, 1'b0);
        check("sll0_result", result, 16'h1234);
        check("sll0_flags", flags(), 4'b0000);

        // Reset during an SRA by 7, asserted in the third cycle after accept.
        go(OP_SRA, 16'h8000, 16'h0007, 16'h0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("abort_result", result, 16'h0);
        check("abort_flags", flags(), 4'b0000);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b0);
        go(OP_ADD, 16'h0001, 16'h0001, 16'h0);
        check("post_rst_done", done, 1'b1);
        check("post_rst_result", result, 16'h0002);
        cyc(); cyc(); cyc(); cyc(); cyc();
        check("abort_no_late_done", done, 1'b0);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        go(OP_ADD, 16'h0003, 16'h0004, 16'h0);
        rst = 1'b0;
        check("rst_prio_done", done, 1'b0);
        check("rst_prio_result", result, 16'h0);

        // Back-to-back XOR then IN.
        opcode = OP_XOR; in1 = 16'h00FF; in2 = 16'h0F0F; start = 1'b1;
        cyc();
        check("xor_done", done, 1'b1);
        check("xor_result", result, 16'h0FF0);
        check("xor_flags", flags(), 4'b0000);
        opcode = OP_IN; dipswitch = 16'hA5A5;
        cyc();
        start = 1'b0;
        check("in_done", done, 1'b1);
        check("in_result", result, 16'hA5A5);
        check("in_flags", flags(), 4'b0001);
        check("in_we", result_we, 1'b1);
        cyc();
        check("in_done_pulse", done, 1'b0);

        go(4'd7, 16'h1234, 16'h5678, 16'h0);
        check("undef_done", done, 1'b1);
        check("undef_result", result, 16'h0);
        check("undef_flags", flags(), 4'b0000);
        check("undef_we", result_we, 1'b0);

        go(OP_MOV, 16'hC0DE, 16'h0, 16'h0);
        check("mov_result", result, 16'hC0DE);
        check("mov_flags", flags(), 4'b0001);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
